// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: operand forwarding,
// load-use stalls, a single-entry MDU scoreboard and branch squash of ID.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int FWD_WB   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_wn,
    input  logic              id_mdu,
    input  logic              ex_wreg,
    input  logic              mem_wreg,
    input  logic              wb_wreg,
    input  logic [REG_AW-1:0] ex_wn,
    input  logic [REG_AW-1:0] mem_wn,
    input  logic [REG_AW-1:0] wb_wn,
    input  logic              ex_m2reg,
    input  logic              br_taken,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic              mdu_start,
    output logic              mdu_busy,
    output logic              mdu_done
);

    localparam logic [1:0] LCNT_INIT = 2'(LOAD_LAT - 1);
    localparam logic [3:0] MCNT_INIT = 4'(MDU_LAT);

    logic [1:0]        lcnt;
    logic [3:0]        mcnt;
    logic [REG_AW-1:0] mdu_wn;

    logic luse;
    logic ld_stall;
    logic mdu_hz;
    logic stall;
    logic start_ok;

    // Youngest producer wins; r0 is hardwired zero and never forwarded.
    function automatic logic [2:0] fwd_sel(input logic use_r, input logic [REG_AW-1:0] src);
        logic [2:0] sel;
        sel = 3'b000;
        if (!use_r)
            sel = 3'b001;
        else if (src != '0) begin
            if (ex_wreg && ex_wn == src)
                sel = 3'b010;
            else if (mem_wreg && mem_wn == src)
                sel = 3'b011;
            else if (FWD_WB != 0 && wb_wreg && wb_wn == src)
                sel = 3'b100;
        end
        return sel;
    endfunction

    always_comb begin
        luse = ex_m2reg && ex_wreg && (ex_wn != '0) &&
               ((id_use_rs && id_rs == ex_wn) || (id_use_rt && id_rt == ex_wn));
        ld_stall = (luse && lcnt == 2'd0) || (lcnt != 2'd0);
        mdu_hz = mdu_busy && (id_mdu ||
                              (id_use_rs && id_rs == mdu_wn) ||
                              (id_use_rt && id_rt == mdu_wn) ||
                              (id_wreg && id_wn == mdu_wn));
        stall    = ld_stall || mdu_hz;
        start_ok = id_mdu && !ld_stall && !mdu_hz && !br_taken;
    end

    always_comb begin
        fwd_a     = 3'b000;
        fwd_b     = 3'b000;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b1;
        flush_id  = 1'b1;
        mdu_start = 1'b0;
        mdu_done  = 1'b0;
        if (!rst) begin
            fwd_a     = fwd_sel(id_use_rs, id_rs);
            fwd_b     = fwd_sel(id_use_rt, id_rt);
            stall_if  = stall && !br_taken;
            stall_id  = stall && !br_taken;
            bubble_ex = stall || br_taken;
            flush_id  = br_taken;
            mdu_start = start_ok;
            mdu_done  = mdu_busy && mcnt == 4'd1;
        end
    end

    // A taken branch squashes the dependent in ID, so any pending load stall is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lcnt <= 2'd0;
        else if (br_taken)
            lcnt <= 2'd0;
        else if (lcnt != 2'd0)
            lcnt <= lcnt - 2'd1;
        else if (luse)
            lcnt <= LCNT_INIT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_busy <= 1'b0;
            mcnt     <= 4'd0;
            mdu_wn   <= '0;
        end else if (start_ok) begin
            mdu_busy <= 1'b1;
            mcnt     <= MCNT_INIT;
            mdu_wn   <= id_wn;
        end else if (mdu_busy) begin
            mcnt <= mcnt - 4'd1;
            if (mcnt == 4'd1)
                mdu_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances (default, LOAD_LAT=2, FWD_WB=0)
// share one set of inputs.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] id_rs, id_rt, id_wn, ex_wn, mem_wn, wb_wn;
    logic          id_use_rs, id_use_rt, id_wreg, id_mdu;
    logic          ex_wreg, mem_wreg, wb_wreg, ex_m2reg, br_taken;

    logic [2:0] fwd_a [3];
    logic [2:0] fwd_b [3];
    logic       stall_if [3];
    logic       stall_id [3];
    logic       bubble_ex [3];
    logic       flush_id [3];
    logic       mdu_start [3];
    logic       mdu_busy [3];
    logic       mdu_done [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .REG_AW  (AW),
            .LOAD_LAT(g == 1 ? 2 : 1),
            .MDU_LAT (4),
            .FWD_WB  (g == 2 ? 0 : 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .id_rs    (id_rs),
            .id_rt    (id_rt),
            .id_use_rs(id_use_rs),
            .id_use_rt(id_use_rt),
            .id_wreg  (id_wreg),
            .id_wn    (id_wn),
            .id_mdu   (id_mdu),
            .ex_wreg  (ex_wreg),
            .mem_wreg (mem_wreg),
            .wb_wreg  (wb_wreg),
            .ex_wn    (ex_wn),
            .mem_wn   (mem_wn),
            .wb_wn    (wb_wn),
            .ex_m2reg (ex_m2reg),
            .br_taken (br_taken),
            .fwd_a    (fwd_a[g]),
            .fwd_b    (fwd_b[g]),
            .stall_if (stall_if[g]),
            .stall_id (stall_id[g]),
            .bubble_ex(bubble_ex[g]),
            .flush_id (flush_id[g]),
            .mdu_start(mdu_start[g]),
            .mdu_busy (mdu_busy[g]),
            .mdu_done (mdu_done[g])
        );
    end

    typedef struct {
        logic [AW-1:0] rs, rt, ex_wn, mem_wn, wb_wn;
        logic          use_rs, use_rt, ex_wreg, mem_wreg, wb_wreg, ex_m2reg;
        logic [2:0]    exp_a, exp_a_nowb, exp_b;
        logic          exp_stall;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_wn = '0; ex_wn = '0; mem_wn = '0; wb_wn = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_wreg = 1'b0; id_mdu = 1'b0;
        ex_wreg = 1'b0; mem_wreg = 1'b0; wb_wreg = 1'b0; ex_m2reg = 1'b0; br_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // rs=3 use_rs, rt=0 use_rt; all stages write r3
        vecs[0] = '{rs:3, rt:0, ex_wn:3, mem_wn:3, wb_wn:3, use_rs:1, use_rt:1, ex_wreg:1, mem_wreg:1,
                    wb_wreg:1, ex_m2reg:0, exp_a:3'b010, exp_a_nowb:3'b010, exp_b:3'b000, exp_stall:0};
        vecs[1] = '{rs:3, rt:0, ex_wn:3, mem_wn:3, wb_wn:3, use_rs:1, use_rt:1, ex_wreg:0, mem_wreg:1,
                    wb_wreg:1, ex_m2reg:0, exp_a:3'b011, exp_a_nowb:3'b011, exp_b:3'b000, exp_stall:0};
        vecs[2] = '{rs:3, rt:0, ex_wn:3, mem_wn:3, wb_wn:3, use_rs:1, use_rt:1, ex_wreg:0, mem_wreg:0,
                    wb_wreg:1, ex_m2reg:0, exp_a:3'b100, exp_a_nowb:3'b000, exp_b:3'b000, exp_stall:0};
        vecs[3] = '{rs:0, rt:0, ex_wn:0, mem_wn:0, wb_wn:0, use_rs:1, use_rt:1, ex_wreg:1, mem_wreg:1,
                    wb_wreg:1, ex_m2reg:0, exp_a:3'b000, exp_a_nowb:3'b000, exp_b:3'b000, exp_stall:0};
        vecs[4] = '{rs:3, rt:4, ex_wn:3, mem_wn:4, wb_wn:0, use_rs:0, use_rt:1, ex_wreg:1, mem_wreg:1,
                    wb_wreg:0, ex_m2reg:1, exp_a:3'b001, exp_a_nowb:3'b001, exp_b:3'b011, exp_stall:0};
        vecs[5] = '{rs:2, rt:6, ex_wn:2, mem_wn:6, wb_wn:6, use_rs:1, use_rt:1, ex_wreg:1, mem_wreg:1,
                    wb_wreg:1, ex_m2reg:0, exp_a:3'b010, exp_a_nowb:3'b010, exp_b:3'b011, exp_stall:0};
        vecs[6] = '{rs:2, rt:6, ex_wn:2, mem_wn:6, wb_wn:6, use_rs:1, use_rt:0, ex_wreg:1, mem_wreg:1,
                    wb_wreg:1, ex_m2reg:0, exp_a:3'b010, exp_a_nowb:3'b010, exp_b:3'b001, exp_stall:0};
        vecs[7] = '{rs:1, rt:2, ex_wn:5, mem_wn:6, wb_wn:7, use_rs:1, use_rt:1, ex_wreg:1, mem_wreg:1,
                    wb_wreg:1, ex_m2reg:0, exp_a:3'b000, exp_a_nowb:3'b000, exp_b:3'b000, exp_stall:0};
        vecs[8] = '{rs:5, rt:0, ex_wn:5, mem_wn:0, wb_wn:0, use_rs:1, use_rt:0, ex_wreg:1, mem_wreg:0,
                    wb_wreg:0, ex_m2reg:1, exp_a:3'b010, exp_a_nowb:3'b010, exp_b:3'b001, exp_stall:1};

        // Reset: inputs that would forward and stall must be overridden
        clear_inputs();
        id_rs = 3; id_use_rs = 1'b1; ex_wreg = 1'b1; ex_wn = 3; ex_m2reg = 1'b1; id_mdu = 1'b1;
        repeat (2) @(posedge clk);
        sample();
        check("rst_fwd_a", int'(fwd_a[0]), 0);
        check("rst_stall_if", int'(stall_if[0]), 0);
        check("rst_stall_id", int'(stall_id[0]), 0);
        check("rst_bubble_ex", int'(bubble_ex[0]), 1);
        check("rst_flush_id", int'(flush_id[0]), 1);
        check("rst_mdu_start", int'(mdu_start[0]), 0);
        check("rst_mdu_busy", int'(mdu_busy[0]), 0);
        clear_inputs();
        next_cycle();
        rst = 1'b0;

        // Forwarding table
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
            ex_wn = vecs[i].ex_wn; mem_wn = vecs[i].mem_wn; wb_wn = vecs[i].wb_wn;
            ex_wreg = vecs[i].ex_wreg; mem_wreg = vecs[i].mem_wreg; wb_wreg = vecs[i].wb_wreg;
            ex_m2reg = vecs[i].ex_m2reg;
            sample();
            check($sformatf("vec%0d_fwd_a", i), int'(fwd_a[0]), int'(vecs[i].exp_a));
            check($sformatf("vec%0d_fwd_a_nowb", i), int'(fwd_a[2]), int'(vecs[i].exp_a_nowb));
            check($sformatf("vec%0d_fwd_b", i), int'(fwd_b[0]), int'(vecs[i].exp_b));
            check($sformatf("vec%0d_stall", i), int'(stall_if[0]), int'(vecs[i].exp_stall));
        end

        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;

        // Load-use: LOAD_LAT=1 (dut0) and LOAD_LAT=2 (dut1)
        next_cycle();
        ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_wn = 5; id_rt = 5; id_use_rt = 1'b1;
        sample();
        check("luse_c0_stall_if", int'(stall_if[0]), 1);
        check("luse_c0_stall_id", int'(stall_id[0]), 1);
        check("luse_c0_bubble", int'(bubble_ex[0]), 1);
        check("luse2_c0_stall_if", int'(stall_if[1]), 1);
        next_cycle();
        ex_m2reg = 1'b0; ex_wreg = 1'b0; ex_wn = 0; mem_wreg = 1'b1; mem_wn = 5;
        sample();
        check("luse_c1_stall_if", int'(stall_if[0]), 0);
        check("luse_c1_bubble", int'(bubble_ex[0]), 0);
        check("luse_c1_fwd_b", int'(fwd_b[0]), 3);
        check("luse2_c1_stall_if", int'(stall_if[1]), 1);
        check("luse2_c1_bubble", int'(bubble_ex[1]), 1);
        next_cycle();
        mem_wreg = 1'b0; mem_wn = 0; wb_wreg = 1'b1; wb_wn = 5;
        sample();
        check("luse2_c2_stall_if", int'(stall_if[1]), 0);
        check("luse2_c2_fwd_b", int'(fwd_b[1]), 4);
        clear_inputs();

        // MDU issue, then dependent on r7 stalls for the full latency
        next_cycle();
        id_mdu = 1'b1; id_wreg = 1'b1; id_wn = 7;
        sample();
        check("mdu_start", int'(mdu_start[0]), 1);
        check("mdu_busy_c0", int'(mdu_busy[0]), 0);
        next_cycle();
        id_mdu = 1'b0; id_wreg = 1'b1; id_wn = 9; id_rs = 7; id_use_rs = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            sample();
            check($sformatf("mdu_dep_busy_c%0d", c), int'(mdu_busy[0]), 1);
            check($sformatf("mdu_dep_stall_c%0d", c), int'(stall_if[0]), 1);
            check($sformatf("mdu_dep_done_c%0d", c), int'(mdu_done[0]), (c == 4) ? 1 : 0);
            next_cycle();
        end
        sample();
        check("mdu_dep_release_stall", int'(stall_if[0]), 0);
        check("mdu_dep_release_busy", int'(mdu_busy[0]), 0);

        // Second MDU op waits for the first
        next_cycle();
        clear_inputs();
        id_mdu = 1'b1; id_wreg = 1'b1; id_wn = 7;
        sample();
        check("mdu2_first_start", int'(mdu_start[0]), 1);
        next_cycle();
        id_wn = 10;
        for (int c = 1; c <= 4; c++) begin
            sample();
            check($sformatf("mdu2_stall_c%0d", c), int'(stall_id[0]), 1);
            check($sformatf("mdu2_nostart_c%0d", c), int'(mdu_start[0]), 0);
            next_cycle();
        end
        sample();
        check("mdu2_second_start", int'(mdu_start[0]), 1);

        // Unrelated r8 instruction issues while the MDU is busy
        next_cycle();
        clear_inputs();
        id_rs = 8; id_use_rs = 1'b1; id_wreg = 1'b1; id_wn = 8;
        sample();
        check("unrel_busy", int'(mdu_busy[0]), 1);
        check("unrel_stall", int'(stall_if[0]), 0);

        // Async reset with mcnt=2
        next_cycle();
        clear_inputs();
        next_cycle();
        rst = 1'b1;
        #1;
        check("arst_busy", int'(mdu_busy[0]), 0);
        check("arst_bubble", int'(bubble_ex[0]), 1);
        check("arst_flush", int'(flush_id[0]), 1);
        check("arst_stall_if", int'(stall_if[0]), 0);
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("arst_done_c%0d", c), int'(mdu_done[0]), 0);
        end
        next_cycle();
        rst = 1'b0;
        sample();
        check("arst_post_busy", int'(mdu_busy[0]), 0);
        check("arst_post_done", int'(mdu_done[0]), 0);

        // Fresh MDU op after reset runs the full latency
        next_cycle();
        id_mdu = 1'b1; id_wreg = 1'b1; id_wn = 11;
        sample();
        check("fresh_start", int'(mdu_start[0]), 1);
        begin
            int k;
            k = 0;
            for (int c = 1; c <= 20; c++) begin
                next_cycle();
                clear_inputs();
                sample();
                if (mdu_done[0]) begin
                    k = c;
                    break;
                end
            end
            check("fresh_done_cycle", k, 4);
        end

        // Branch overrides a load-use stall and clears the load counter (LOAD_LAT=2)
        next_cycle();
        clear_inputs();
        ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_wn = 5; id_rt = 5; id_use_rt = 1'b1; br_taken = 1'b1;
        sample();
        check("br_flush", int'(flush_id[1]), 1);
        check("br_bubble", int'(bubble_ex[1]), 1);
        check("br_stall_if", int'(stall_if[1]), 0);
        check("br_stall_id", int'(stall_id[1]), 0);
        check("br_stall_if_lat1", int'(stall_if[0]), 0);
        next_cycle();
        clear_inputs();
        sample();
        check("br_lcnt_cleared", int'(stall_if[1]), 0);
        check("br_next_flush", int'(flush_id[1]), 0);

        // Branch blocks MDU issue
        next_cycle();
        id_mdu = 1'b1; id_wreg = 1'b1; id_wn = 7; br_taken = 1'b1;
        sample();
        check("br_mdu_nostart", int'(mdu_start[0]), 0);
        next_cycle();
        clear_inputs();
        sample();
        check("br_mdu_notbusy", int'(mdu_busy[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end

endmodule
